// File: rtl/egress_rr_drain.sv
// Round-robin drain of switch output FIFOs 4..7 into one valid/ready stream, with per-FIFO delivery counters.
// Pop-to-data_out latency is 2 cycles; a stall parks at most one word in the skid and stops popping until it drains.
module egress_rr_drain #(
    parameter int data_width = 10,
    parameter int cnt_width  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            fifo_empty,
    input  logic [data_width-1:0] fifo_data0,
    input  logic [data_width-1:0] fifo_data1,
    input  logic [data_width-1:0] fifo_data2,
    input  logic [data_width-1:0] fifo_data3,
    output logic                  pop0,
    output logic                  pop1,
    output logic                  pop2,
    output logic                  pop3,
    output logic [data_width-1:0] data_out,
    output logic                  valid_out,
    input  logic                  ready_out,
    output logic [1:0]            src_out,
    input  logic                  cnt_req,
    input  logic [1:0]            cnt_sel,
    output logic [cnt_width-1:0]  cnt_data,
    output logic                  cnt_valid,
    output logic                  idle
);

    logic [1:0]            r_last_grant;
    logic                  r_inflight;
    logic [1:0]            r_inflight_src;
    logic                  r_skid_vld;
    logic [data_width-1:0] r_skid_dat;
    logic [1:0]            r_skid_src;
    logic                  r_out_vld;
    logic [data_width-1:0] r_out_dat;
    logic [1:0]            r_out_src;
    logic [cnt_width-1:0]  r_cnt [4];
    logic [cnt_width-1:0]  r_cnt_data;
    logic                  r_cnt_valid;

    logic                  w_xfer;
    logic                  w_out_free;
    logic                  w_pop_en;
    logic [1:0]            w_grant;
    logic                  w_found;
    logic [3:0]            w_pop;
    logic [data_width-1:0] w_in_dat;

    assign w_xfer     = r_out_vld & ready_out;
    assign w_out_free = ~r_out_vld | ready_out;
    // Popping only with an empty skid is what bounds the skid to a single word.
    assign w_pop_en   = reset & ~r_skid_vld & w_out_free & ~(&fifo_empty);

    always_comb begin
        w_grant = r_last_grant;
        w_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!w_found && !fifo_empty[r_last_grant + 2'(k)]) begin
                w_found = 1'b1;
                w_grant = r_last_grant + 2'(k);
            end
        end
    end

    assign w_pop = w_pop_en ? (4'b0001 << w_grant) : 4'b0000;
    assign pop0  = w_pop[0];
    assign pop1  = w_pop[1];
    assign pop2  = w_pop[2];
    assign pop3  = w_pop[3];

    always_comb begin
        case (r_inflight_src)
            2'd0:    w_in_dat = fifo_data0;
            2'd1:    w_in_dat = fifo_data1;
            2'd2:    w_in_dat = fifo_data2;
            default: w_in_dat = fifo_data3;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant   <= 2'd3;
            r_inflight     <= 1'b0;
            r_inflight_src <= 2'd0;
            r_skid_vld     <= 1'b0;
            r_skid_dat     <= '0;
            r_skid_src     <= 2'd0;
            r_out_vld      <= 1'b0;
            r_out_dat      <= '0;
            r_out_src      <= 2'd0;
            r_cnt_data     <= '0;
            r_cnt_valid    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_inflight <= w_pop_en;
            if (w_pop_en) begin
                r_inflight_src <= w_grant;
                r_last_grant   <= w_grant;
            end

            if (r_skid_vld) begin
                if (w_xfer) begin
                    r_out_dat  <= r_skid_dat;
                    r_out_src  <= r_skid_src;
                    r_skid_vld <= r_inflight;
                    if (r_inflight) begin
                        r_skid_dat <= w_in_dat;
                        r_skid_src <= r_inflight_src;
                    end
                end
            end else if (r_inflight) begin
                if (w_out_free) begin
                    r_out_vld <= 1'b1;
                    r_out_dat <= w_in_dat;
                    r_out_src <= r_inflight_src;
                end else begin
                    r_skid_vld <= 1'b1;
                    r_skid_dat <= w_in_dat;
                    r_skid_src <= r_inflight_src;
                end
            end else if (w_xfer) begin
                r_out_vld <= 1'b0;
            end

            if (w_xfer) begin
                r_cnt[r_out_src] <= r_cnt[r_out_src] + {{(cnt_width-1){1'b0}}, 1'b1};
            end

            // Reads see the counter before any increment landing on the same edge.
            r_cnt_valid <= cnt_req;
            if (cnt_req) begin
                r_cnt_data <= r_cnt[cnt_sel];
            end
        end
    end

    assign data_out  = r_out_dat;
    assign valid_out = r_out_vld;
    assign src_out   = r_out_src;
    assign cnt_data  = r_cnt_data;
    assign cnt_valid = r_cnt_valid;
    assign idle      = (&fifo_empty) & ~r_inflight & ~r_skid_vld & ~r_out_vld;

endmodule

// File: tb/tb_egress_rr_drain.sv
// Directed bench for egress_rr_drain with behavioural models of FIFOs 4..7.
module tb_egress_rr_drain;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] fifo_empty;
    logic [9:0] fifo_data0, fifo_data1, fifo_data2, fifo_data3;
    logic       pop0, pop1, pop2, pop3;
    logic [9:0] data_out;
    logic       valid_out;
    logic       ready_out;
    logic [1:0] src_out;
    logic       cnt_req;
    logic [1:0] cnt_sel;
    logic [7:0] cnt_data;
    logic       cnt_valid;
    logic       idle;

    int n_checks = 0;
    int n_fail   = 0;

    logic [9:0] mem [4][1024];
    int         wp [4] = '{0, 0, 0, 0};
    int         rp [4] = '{0, 0, 0, 0};
    int         pop_cnt [4] = '{0, 0, 0, 0};
    logic [9:0] fdat [4];
    logic [3:0] w_pop;
    logic [9:0] obs_d [$];
    logic [1:0] obs_s [$];

    always #5 clk = ~clk;

    egress_rr_drain #(.data_width(10), .cnt_width(8)) dut (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty),
        .fifo_data0(fifo_data0), .fifo_data1(fifo_data1),
        .fifo_data2(fifo_data2), .fifo_data3(fifo_data3),
        .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
        .data_out(data_out), .valid_out(valid_out), .ready_out(ready_out),
        .src_out(src_out), .cnt_req(cnt_req), .cnt_sel(cnt_sel),
        .cnt_data(cnt_data), .cnt_valid(cnt_valid), .idle(idle)
    );

    assign w_pop = {pop3, pop2, pop1, pop0};
    assign fifo_empty[0] = (wp[0] == rp[0]);
    assign fifo_empty[1] = (wp[1] == rp[1]);
    assign fifo_empty[2] = (wp[2] == rp[2]);
    assign fifo_empty[3] = (wp[3] == rp[3]);
    assign fifo_data0 = fdat[0];
    assign fifo_data1 = fdat[1];
    assign fifo_data2 = fdat[2];
    assign fifo_data3 = fdat[3];

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_pop[i]) begin
                fdat[i]    <= mem[i][rp[i] % 1024];
                rp[i]      <= rp[i] + 1;
                pop_cnt[i] <= pop_cnt[i] + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (reset && valid_out && ready_out) begin
            obs_d.push_back(data_out);
            obs_s.push_back(src_out);
        end
    end

    task automatic push(input int f, input logic [9:0] d);
        mem[f][wp[f] % 1024] = d;
        wp[f] = wp[f] + 1;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (idle) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic read_cnt(input logic [1:0] sel, output logic [7:0] val,
                            output logic v0, output logic v1, output logic v2);
        @(negedge clk);
        cnt_req = 1'b1; cnt_sel = sel;
        #1 v0 = cnt_valid;
        @(negedge clk);
        cnt_req = 1'b0;
        #1 val = cnt_data; v1 = cnt_valid;
        @(negedge clk);
        #1 v2 = cnt_valid;
    endtask

    task automatic test_reset;
        reset = 1'b0; ready_out = 1'b0; cnt_req = 1'b0; cnt_sel = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (data_out !== 10'h000) begin n_fail++; $display("FAIL rst_data: got %0h want 0", data_out); end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", valid_out); end
        n_checks++; if (src_out !== 2'd0) begin n_fail++; $display("FAIL rst_src: got %0d want 0", src_out); end
        n_checks++; if (w_pop !== 4'b0000) begin n_fail++; $display("FAIL rst_pop: got %b want 0000", w_pop); end
        n_checks++; if (cnt_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cnt_valid: got %0b want 0", cnt_valid); end
        n_checks++; if (cnt_data !== 8'h00) begin n_fail++; $display("FAIL rst_cnt_data: got %0h want 0", cnt_data); end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL rst_idle: got %0b want 1", idle); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single;
        logic [3:0] ep;
        logic       ev;
        logic [7:0] val;
        logic       v0, v1, v2;
        @(negedge clk);
        push(0, 10'h090); push(0, 10'h091); push(0, 10'h092);
        ready_out = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            ep = (k < 3) ? 4'b0001 : 4'b0000;
            ev = (k >= 2 && k <= 4);
            n_checks++; if (w_pop !== ep) begin n_fail++; $display("FAIL single_pop c%0d: got %b want %b", k, w_pop, ep); end
            n_checks++; if (valid_out !== ev) begin n_fail++; $display("FAIL single_valid c%0d: got %0b want %0b", k, valid_out, ev); end
            if (ev) begin
                n_checks++; if (data_out !== 10'h090 + 10'(k - 2)) begin n_fail++; $display("FAIL single_data c%0d: got %0h want %0h", k, data_out, 10'h090 + 10'(k - 2)); end
                n_checks++; if (src_out !== 2'd0) begin n_fail++; $display("FAIL single_src c%0d: got %0d want 0", k, src_out); end
            end
        end
        read_cnt(2'd0, val, v0, v1, v2);
        n_checks++; if (val !== 8'd3) begin n_fail++; $display("FAIL single_cnt0: got %0d want 3", val); end
        n_checks++; if ({v0, v1, v2} !== 3'b010) begin n_fail++; $display("FAIL single_cnt_valid: got %b want 010", {v0, v1, v2}); end
    endtask

    task automatic test_counter_wrap;
        int         base;
        int         bad;
        bit         ok;
        logic [7:0] val;
        logic       v0, v1, v2;
        base = obs_d.size();
        @(negedge clk);
        for (int i = 0; i < 257; i++) push(3, 10'(i + 256));
        ready_out = 1'b1;
        #1;
        wait_idle(600, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_drain_timeout: got busy want idle"); end
        n_checks++; if (obs_d.size() - base !== 257) begin n_fail++; $display("FAIL wrap_count: got %0d want 257", obs_d.size() - base); end
        bad = 0;
        for (int i = 0; i < 257 && base + i < obs_d.size(); i++) begin
            if (obs_d[base + i] !== 10'(i + 256) || obs_s[base + i] !== 2'd3) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL wrap_data: got %0d bad words want 0", bad); end
        read_cnt(2'd3, val, v0, v1, v2);
        n_checks++; if (val !== 8'd1) begin n_fail++; $display("FAIL wrap_cnt3: got %0d want 1", val); end
        n_checks++; if ({v0, v1, v2} !== 3'b010) begin n_fail++; $display("FAIL wrap_cnt_valid: got %b want 010", {v0, v1, v2}); end
    endtask

    task automatic test_round_robin;
        logic [9:0] exp_d [8] = '{10'h1A0, 10'h2B0, 10'h3C0, 10'h0D0, 10'h1A1, 10'h2B1, 10'h3C1, 10'h0D1};
        logic [3:0] ep;
        @(negedge clk);
        push(0, 10'h1A0); push(0, 10'h1A1);
        push(1, 10'h2B0); push(1, 10'h2B1);
        push(2, 10'h3C0); push(2, 10'h3C1);
        push(3, 10'h0D0); push(3, 10'h0D1);
        ready_out = 1'b1;
        #1;
        for (int k = 0; k < 11; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            ep = (k < 8) ? (4'b0001 << (k % 4)) : 4'b0000;
            n_checks++; if (w_pop !== ep) begin n_fail++; $display("FAIL rr_pop c%0d: got %b want %b", k, w_pop, ep); end
            if (k >= 2 && k <= 9) begin
                n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL rr_valid c%0d: got %0b want 1", k, valid_out); end
                n_checks++; if (data_out !== exp_d[k - 2]) begin n_fail++; $display("FAIL rr_data c%0d: got %0h want %0h", k, data_out, exp_d[k - 2]); end
                n_checks++; if (src_out !== 2'((k - 2) % 4)) begin n_fail++; $display("FAIL rr_src c%0d: got %0d want %0d", k, src_out, (k - 2) % 4); end
            end
        end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rr_tail_valid: got %0b want 0", valid_out); end
    endtask

    task automatic test_backpressure;
        int         base;
        int         p0;
        int         bad;
        bit         ok;
        logic [7:0] val;
        logic       v0, v1, v2;
        base = obs_d.size();
        @(negedge clk);
        for (int i = 0; i < 6; i++) push(1, 10'h150 + 10'(i));
        ready_out = 1'b1;
        p0 = pop_cnt[1];
        #1;
        for (int k = 1; k < 9; k++) begin
            @(negedge clk);
            ready_out = !(k >= 3 && k <= 7);
            #1;
            if (k >= 3 && k <= 7) begin
                n_checks++; if (w_pop !== 4'b0000) begin n_fail++; $display("FAIL bp_pop c%0d: got %b want 0000", k, w_pop); end
                n_checks++; if (valid_out !== 1'b1) begin n_fail++; $display("FAIL bp_valid c%0d: got %0b want 1", k, valid_out); end
                n_checks++; if (data_out !== 10'h151) begin n_fail++; $display("FAIL bp_data c%0d: got %0h want 151", k, data_out); end
                n_checks++; if (src_out !== 2'd1) begin n_fail++; $display("FAIL bp_src c%0d: got %0d want 1", k, src_out); end
            end
            if (k == 7) begin
                n_checks++; if (pop_cnt[1] - p0 !== 3) begin n_fail++; $display("FAIL bp_pops_in_stall: got %0d want 3", pop_cnt[1] - p0); end
                n_checks++; if (obs_d.size() - base !== 1) begin n_fail++; $display("FAIL bp_delivered_in_stall: got %0d want 1", obs_d.size() - base); end
                n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL bp_idle: got %0b want 0", idle); end
            end
        end
        wait_idle(60, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_drain_timeout: got busy want idle"); end
        n_checks++; if (obs_d.size() - base !== 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", obs_d.size() - base); end
        bad = 0;
        for (int i = 0; i < 6 && base + i < obs_d.size(); i++) begin
            if (obs_d[base + i] !== 10'h150 + 10'(i) || obs_s[base + i] !== 2'd1) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_order: got %0d bad words want 0", bad); end
        read_cnt(2'd1, val, v0, v1, v2);
        n_checks++; if (val !== 8'd8) begin n_fail++; $display("FAIL bp_cnt1: got %0d want 8", val); end
    endtask

    task automatic test_empty_boundary;
        int base;
        int p2;
        ready_out = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_checks++; if (w_pop !== 4'b0000) begin n_fail++; $display("FAIL empty_pop c%0d: got %b want 0000", k, w_pop); end
            n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL empty_valid c%0d: got %0b want 0", k, valid_out); end
            n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL empty_idle c%0d: got %0b want 1", k, idle); end
        end
        base = obs_d.size();
        p2 = pop_cnt[2];
        @(negedge clk);
        push(2, 10'h260);
        #1;
        n_checks++; if (w_pop !== 4'b0100) begin n_fail++; $display("FAIL one_pop2: got %b want 0100", w_pop); end
        n_checks++; if (idle !== 1'b0) begin n_fail++; $display("FAIL one_busy: got %0b want 0", idle); end
        @(negedge clk); #1;
        n_checks++; if (w_pop !== 4'b0000) begin n_fail++; $display("FAIL one_pop_after: got %b want 0000", w_pop); end
        repeat (4) @(negedge clk);
        #1;
        n_checks++; if (pop_cnt[2] - p2 !== 1) begin n_fail++; $display("FAIL one_pop_count: got %0d want 1", pop_cnt[2] - p2); end
        n_checks++; if (obs_d.size() - base !== 1) begin n_fail++; $display("FAIL one_count: got %0d want 1", obs_d.size() - base); end
        if (obs_d.size() > base) begin
            n_checks++; if (obs_d[base] !== 10'h260 || obs_s[base] !== 2'd2) begin n_fail++; $display("FAIL one_word: got %0h/%0d want 260/2", obs_d[base], obs_s[base]); end
        end
        n_checks++; if (idle !== 1'b1) begin n_fail++; $display("FAIL one_idle_again: got %0b want 1", idle); end
    endtask

    task automatic test_midstream_reset;
        logic [9:0] exp_d [4] = '{10'h0A2, 10'h0B0, 10'h0A3, 10'h0A4};
        logic [1:0] exp_s [4] = '{2'd0, 2'd1, 2'd0, 2'd0};
        int         base;
        int         p0;
        int         bad;
        bit         ok;
        @(negedge clk);
        ready_out = 1'b0;
        p0 = pop_cnt[0];
        for (int i = 0; i < 5; i++) push(0, 10'h0A0 + 10'(i));
        repeat (5) @(negedge clk);
        #1;
        n_checks++; if (valid_out !== 1'b1 || data_out !== 10'h0A0) begin n_fail++; $display("FAIL mrst_pre_out: got %0b/%0h want 1/0a0", valid_out, data_out); end
        n_checks++; if (pop_cnt[0] - p0 !== 2) begin n_fail++; $display("FAIL mrst_pre_pops: got %0d want 2", pop_cnt[0] - p0); end
        #1 reset = 1'b0;
        #1;
        n_checks++; if (data_out !== 10'h000) begin n_fail++; $display("FAIL mrst_data: got %0h want 0", data_out); end
        n_checks++; if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mrst_valid: got %0b want 0", valid_out); end
        n_checks++; if (src_out !== 2'd0) begin n_fail++; $display("FAIL mrst_src: got %0d want 0", src_out); end
        n_checks++; if (w_pop !== 4'b0000) begin n_fail++; $display("FAIL mrst_pop: got %b want 0000", w_pop); end
        n_checks++; if (cnt_data !== 8'h00) begin n_fail++; $display("FAIL mrst_cnt_data: got %0h want 0", cnt_data); end
        n_checks++; if (cnt_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_cnt_valid: got %0b want 0", cnt_valid); end
        push(1, 10'h0B0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ready_out = 1'b1;
        base = obs_d.size();
        #1;
        n_checks++; if (w_pop !== 4'b0001) begin n_fail++; $display("FAIL mrst_first_grant: got %b want 0001", w_pop); end
        wait_idle(40, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mrst_drain_timeout: got busy want idle"); end
        n_checks++; if (obs_d.size() - base !== 4) begin n_fail++; $display("FAIL mrst_count: got %0d want 4", obs_d.size() - base); end
        bad = 0;
        for (int i = 0; i < 4 && base + i < obs_d.size(); i++) begin
            if (obs_d[base + i] !== exp_d[i] || obs_s[base + i] !== exp_s[i]) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mrst_order: got %0d bad words want 0", bad); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_counter_wrap();
        test_round_robin();
        test_backpressure();
        test_empty_boundary();
        test_midstream_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/egress_rr_drain.md
Name: egress_rr_drain

Overview:
- Downstream stage of the 4-in/4-out FIFO switch module.
- Drains the four output FIFOs (4..7) into one valid/ready word stream using round-robin arbitration.
- Buffers at most one in-flight word in a skid register and counts delivered words per FIFO.
- Drives the FIFO pop strobes directly from the switch's empty flags.

Parameters:
- data_width, 10, word width; matches the switch FIFO width.
- cnt_width, 8, width of each per-FIFO delivered-word counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- fifo_empty  in  4  empty flags of output FIFOs 4..7; bit i refers to FIFO 4+i.
- fifo_data0..fifo_data3  in  data_width each  FIFO 4..7 read data; valid the cycle after the pop.
- pop0..pop3  out  1 each  pop strobes to FIFO 4..7; combinational, single cycle.
- data_out  out  data_width  drained word.
- valid_out  out  1  data_out holds a word.
- ready_out  in  1  downstream accepts; a transfer occurs when valid_out&&ready_out at a clock edge.
- src_out  out  2  index (0..3) of the FIFO data_out came from.
- cnt_req  in  1  counter read request.
- cnt_sel  in  2  counter to read.
- cnt_data  out  cnt_width  selected counter value.
- cnt_valid  out  1  cnt_data valid, one-cycle pulse.
- idle  out  1  no words pending anywhere.

Behaviour:
- Reset (reset=0, asynchronous) clears the following, regardless of in-flight words (the in-flight word is discarded):
  - data_out=0, valid_out=0, src_out=0
  - skid buffer empty
  - inflight=0
  - last_grant=3, so FIFO 0 has first priority
  - all counters 0
  - cnt_data=0, cnt_valid=0
  - pops are combinationally forced to 0.
- Pop eligibility in cycle N: skid empty AND (valid_out=0 OR ready_out=1) AND at least one fifo_empty bit is 0.
- Grant selection:
  - Search starts at last_grant+1 modulo 4 and takes the first non-empty FIFO.
  - Exactly one pop asserted; last_grant updates at the edge ending cycle N.
- Pipeline and latency:
  - Pop in cycle N: the FIFO presents the word in N+1, and the block captures it at the edge ending N+1.
  - The word appears on data_out no earlier than cycle N+2.
  - An inflight flag and inflight source (2 bits) are registered for the pop.
- Capture in cycle N+1, priority order:
  1. If the output register is free or being transferred this edge, the word goes to the output register.
  2. Otherwise it goes to the skid.
- When the skid is full and the output transfers, the skid moves to the output register at the same edge.
- Sustained throughput is one word per cycle while ready_out=1.
- Stall behaviour:
  - ready_out=0 holds data_out, src_out and valid_out stable.
  - At most one word enters the skid; pops stop until the skid drains.
- No underflow: pop is never asserted for a FIFO whose empty bit is 1 in that cycle.
- Counters:
  - Counter i increments on each transfer with src_out=i and wraps from 2^cnt_width-1 to 0.
  - On cnt_req=1 in cycle N, cnt_data carries counter[cnt_sel] as of the edge ending N, and cnt_valid=1 in cycle N+1.
  - If a transfer occurs at the same edge, cnt_data shows the pre-increment value.
- idle is combinational: all fifo_empty bits 1 AND inflight=0 AND skid empty AND valid_out=0.

Test Plan:
- Reset:
  - Stimulus: assert reset=0 mid-stream with valid_out=1 and the skid full.
  - Response: all outputs are 0 immediately, without waiting for a clock edge. After release, the first grant goes to FIFO 0.
- Single FIFO:
  - Stimulus: FIFO 4 holds 0x090, 0x091, 0x092 and ready_out=1.
  - Response: pop0 high for 3 consecutive cycles; data_out shows 0x090, 0x091, 0x092 starting 2 cycles after the first pop; src_out=0; counter0 reads 3.
- Round robin:
  - Stimulus: FIFOs 4..7 each hold 2 words (A0,A1 / B0,B1 / C0,C1 / D0,D1).
  - Response: output order is A0,B0,C0,D0,A1,B1,C1,D1 with no idle cycles.
- Backpressure:
  - Stimulus: ready_out=0 for 5 cycles during a stream from FIFO 5.
  - Response: data_out stable; exactly one word held in the skid; no pops; no loss or duplication after release; counter1 equals the number of words pushed.
- Counter wrap and read:
  - Stimulus: 257 words drained from FIFO 7, then cnt_req=1 with cnt_sel=3.
  - Response: cnt_data=1 and cnt_valid=1 for exactly one cycle.
- Empty boundary:
  - Stimulus: all FIFOs empty.
  - Response: no pops, valid_out=0, idle=1. A single push to FIFO 6 produces exactly one pop2 and then idle=1 again.
